phase_seq_monitor: RTL and testbench

- Downstream consumer of the 2-bit ZERO->ONE->TWO->ZERO phase sequencer; samples its phase output each qualified cycle.
- Locks onto the sequence, checks every transition for legality and counts completed rounds (TWO->ZERO wraps).
- Flags the first illegal sample with a sticky error and captures diagnostics.
- Intended as a formal/simulation harness stage for the yosys pmux sequencer tests.

---
 rtl/phase_seq_monitor.sv | 112 +++++++++++
 tb/tb_phase_seq_monitor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/phase_seq_monitor.sv
// phase_seq_monitor: locks onto a ZERO->ONE->TWO phase stream, checks each transition,
// counts completed rounds (saturating) and captures the first illegal sample. Rev 1.0
`default_nettype none

module phase_seq_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       phase,
  input  logic             clr,
  output logic             locked,
  output logic             round_done,
  output logic [CNT_W-1:0] round_cnt,
  output logic             err,
  output logic [1:0]       err_phase,
  output logic [1:0]       err_exp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [1:0]       r_exp;
  logic             r_round_done;
  logic [CNT_W-1:0] r_round_cnt;
  logic             r_err;
  logic [1:0]       r_err_phase;
  logic [1:0]       r_err_exp;
  logic [1:0]       w_succ;
  logic             w_cnt_full;

  // succ(3) is never consumed: a phase of 3 can never equal the expected value.
  always_comb begin
    w_succ = 2'd0;
    case (phase)
      2'd0:    w_succ = 2'd1;
      2'd1:    w_succ = 2'd2;
      default: w_succ = 2'd0;
    endcase
  end

  assign w_cnt_full = &r_round_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_exp        <= 2'd0;
      r_round_done <= 1'b0;
      r_round_cnt  <= '0;
      r_err        <= 1'b0;
      r_err_phase  <= 2'd0;
      r_err_exp    <= 2'd0;
    end else begin
      r_round_done <= 1'b0;
      if (clr) begin
        r_state     <= S_IDLE;
        r_exp       <= 2'd0;
        r_round_cnt <= '0;
        r_err       <= 1'b0;
        r_err_phase <= 2'd0;
        r_err_exp   <= 2'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (en && (phase == 2'd0)) begin
              r_state <= S_TRACK;
              r_exp   <= 2'd1;
            end
          end
          S_TRACK: begin
            if (en) begin
              if (phase == r_exp) begin
                r_exp <= w_succ;
                // A legal ZERO while tracking closes a TWO->ZERO round.
                if (phase == 2'd0) begin
                  r_round_done <= 1'b1;
                  if (!w_cnt_full) r_round_cnt <= r_round_cnt + C_CNT_ONE;
                end
              end else begin
                r_state     <= S_ERROR;
                r_err       <= 1'b1;
                r_err_phase <= phase;
                r_err_exp   <= r_exp;
              end
            end
          end
          S_ERROR: begin
            r_state <= S_ERROR;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign locked     = (r_state == S_TRACK);
  assign round_done = r_round_done;
  assign round_cnt  = r_round_cnt;
  assign err        = r_err;
  assign err_phase  = r_err_phase;
  assign err_exp    = r_err_exp;

endmodule

`default_nettype wire

// File: tb/tb_phase_seq_monitor.sv
// Scoreboard bench for phase_seq_monitor: directed samples push expected outputs,
// a monitor pops and compares one cycle later.
`default_nettype none

module tb_phase_seq_monitor;

  localparam int CNT_W = 2;
  localparam int VW    = 7 + CNT_W;

  logic             clk;
  logic             reset_n;
  logic             en;
  logic [1:0]       phase;
  logic             clr;
  logic             locked;
  logic             round_done;
  logic [CNT_W-1:0] round_cnt;
  logic             err;
  logic [1:0]       err_phase;
  logic [1:0]       err_exp;

  phase_seq_monitor #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .phase      (phase),
    .clr        (clr),
    .locked     (locked),
    .round_done (round_done),
    .round_cnt  (round_cnt),
    .err        (err),
    .err_phase  (err_phase),
    .err_exp    (err_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] v;
    string         name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [VW-1:0] pk(input logic l, input logic d, input logic [CNT_W-1:0] c,
                                       input logic e, input logic [1:0] ep, input logic [1:0] ee);
    return {l, d, c, e, ep, ee};
  endfunction

  function automatic logic [VW-1:0] act();
    return {locked, round_done, round_cnt, err, err_phase, err_exp};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got {lk,dn,cnt,err,eph,eexp}=%b required %b", name, got, want);
  endtask

  // One qualified sample; the expected outputs apply after the next rising edge.
  task automatic st(input logic e, input logic [1:0] p, input logic c,
                    input logic l, input logic d, input logic [CNT_W-1:0] cn,
                    input logic er, input logic [1:0] ep, input logic [1:0] ee, input string name);
    exp_t x;
    @(negedge clk);
    en = e; phase = p; clr = c;
    x.v = pk(l, d, cn, er, ep, ee);
    x.name = name;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check(x.name, act(), x.v);
      end
    end
  end

  initial begin : stim
    int prev;
    int cur;
    logic [1:0] gated [5];
    gated[0] = 2'd2; gated[1] = 2'd3; gated[2] = 2'd1; gated[3] = 2'd0; gated[4] = 2'd2;

    reset_n = 1'b0; en = 1'b0; phase = 2'd0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", act(), '0);
    @(negedge clk) reset_n = 1'b1;

    // Lock and two full rounds
    st(1, 0, 0, 1, 0, 0, 0, 0, 0, "t1_lock0");
    st(1, 1, 0, 1, 0, 0, 0, 0, 0, "t1_p1");
    st(1, 2, 0, 1, 0, 0, 0, 0, 0, "t1_p2");
    st(1, 0, 0, 1, 1, 1, 0, 0, 0, "t1_wrap1");
    st(1, 1, 0, 1, 0, 1, 0, 0, 0, "t1_p1b");
    st(1, 2, 0, 1, 0, 1, 0, 0, 0, "t1_p2b");
    st(1, 0, 0, 1, 1, 2, 0, 0, 0, "t1_wrap2");
    st(0, 0, 1, 0, 0, 0, 0, 0, 0, "t1_clr");

    // Junk before lock raises nothing
    st(1, 2, 0, 0, 0, 0, 0, 0, 0, "t2_pre2");
    st(1, 1, 0, 0, 0, 0, 0, 0, 0, "t2_pre1");
    st(1, 3, 0, 0, 0, 0, 0, 0, 0, "t2_pre3");
    st(1, 0, 0, 1, 0, 0, 0, 0, 0, "t2_lock");
    st(1, 1, 0, 1, 0, 0, 0, 0, 0, "t2_p1");
    st(0, 0, 1, 0, 0, 0, 0, 0, 0, "t2_clr");

    // Illegal value 3, then frozen outputs
    st(1, 0, 0, 1, 0, 0, 0, 0, 0, "t3_lock");
    st(1, 1, 0, 1, 0, 0, 0, 0, 0, "t3_p1");
    st(1, 3, 0, 0, 0, 0, 1, 3, 2, "t3_illegal");
    for (int i = 0; i < 10; i++)
      st(1, 2'(i % 3), 0, 0, 0, 0, 1, 3, 2, "t3_frozen");

    // clr wins over a ZERO sample in the same cycle
    st(1, 0, 1, 0, 0, 0, 0, 0, 0, "t6_clr_prio");
    st(0, 0, 0, 0, 0, 0, 0, 0, 0, "t6_no_lock");

    // Gated cycles ignored, repeated ONE errors
    st(1, 0, 0, 1, 0, 0, 0, 0, 0, "t4_lock");
    for (int i = 0; i < 5; i++)
      st(0, gated[i], 0, 1, 0, 0, 0, 0, 0, "t4_gated");
    st(1, 1, 0, 1, 0, 0, 0, 0, 0, "t4_p1");
    st(1, 1, 0, 0, 0, 0, 1, 1, 2, "t4_repeat");
    st(0, 0, 1, 0, 0, 0, 0, 0, 0, "t4_clr");

    // Saturation with a 2-bit counter: 1,2,3,3,3
    st(1, 0, 0, 1, 0, 0, 0, 0, 0, "t5_lock");
    for (int r = 1; r <= 5; r++) begin
      prev = (r - 1 > 3) ? 3 : r - 1;
      cur  = (r > 3) ? 3 : r;
      st(1, 1, 0, 1, 0, CNT_W'(prev), 0, 0, 0, "t5_p1");
      st(1, 2, 0, 1, 0, CNT_W'(prev), 0, 0, 0, "t5_p2");
      st(1, 0, 0, 1, 1, CNT_W'(cur), 0, 0, 0, "t5_wrap");
    end
    st(1, 1, 0, 1, 0, 3, 0, 0, 0, "t6_midround");

    // Async reset between edges
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1 check("t6_async_reset", act(), '0);
    @(negedge clk);
    check("t6_reset_held", act(), '0);
    reset_n = 1'b1;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
